// File: rtl/mealy_pattern_detector.sv
// Serial Mealy detector for a run-time programmable pattern of 2..MAX_LEN bits,
// with input-valid gating, overlap mode select and a saturating match counter.
module mealy_pattern_detector #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               clear_cnt,
    output logic               out,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

    logic [MAX_LEN-2:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   pat_len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cfg_err_q;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_p1;
    logic               fill_ok;
    logic               match;

    // Newest bit sits at window[0]; only the low pat_len bits take part in the compare.
    always_comb begin
        window  = {hist_q, in};
        mask    = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(pat_len_q));
        end
        fill_p1 = {1'b0, fill_q} + (LEN_W + 1)'(1);
        fill_ok = (fill_p1 >= {1'b0, pat_len_q});
        match   = in_valid && !cfg_load && !cfg_err_q && fill_ok &&
                  (((window ^ pat_q) & mask) == '0);
    end

    assign out         = match;
    assign match_count = cnt_q;
    assign cfg_err     = cfg_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= '0;
            pat_len_q <= '0;
            overlap_q <= 1'b0;
            cfg_err_q <= 1'b1;
        end else if (cfg_load) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= pattern;
            pat_len_q <= pat_len;
            overlap_q <= overlap;
            cfg_err_q <= (pat_len < LEN_W'(2)) || (pat_len > LEN_W'(MAX_LEN));
        end else if (in_valid) begin
            if (match && !overlap_q) begin
                // Non-overlapping: the next match must be built from fresh bits only.
                hist_q <= '0;
                fill_q <= '0;
            end else begin
                hist_q <= window[MAX_LEN-2:0];
                if (fill_q < FILL_MAX) begin
                    fill_q <= fill_q + LEN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear_cnt) begin
            cnt_q <= '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mealy_pattern_detector.sv
// Scoreboard bench for mealy_pattern_detector: a default instance plus a 2-bit counter instance.
module tb_mealy_pattern_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk;
    logic               reset_n;
    logic               in;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap;
    logic               clear_cnt;
    logic               out;
    logic [15:0]        match_count;
    logic               cfg_err;
    logic               out_s;
    logic [1:0]         match_count_s;
    logic               cfg_err_s;

    int errors = 0;
    int checks = 0;
    int cnt_model = 0;
    int sat_model = 0;
    logic exp_q[$];

    mealy_pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .in(in), .in_valid(in_valid),
        .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
        .overlap(overlap), .clear_cnt(clear_cnt), .out(out),
        .match_count(match_count), .cfg_err(cfg_err)
    );

    mealy_pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .in(in), .in_valid(in_valid),
        .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
        .overlap(overlap), .clear_cnt(clear_cnt), .out(out_s),
        .match_count(match_count_s), .cfg_err(cfg_err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        check_val({tag, ".cnt"}, 32'(match_count), 32'(cnt_model));
        check_val({tag, ".cnt_sat"}, 32'(match_count_s), 32'(sat_model));
    endtask

    // Drive one cycle just after a rising edge; the expected strobe goes into the
    // scoreboard and is popped when out is sampled at the falling edge.
    task automatic step(input logic b, input logic v, input logic clr, input logic exp_o,
                        input string tag);
        logic e;
        in        = b;
        in_valid  = v;
        clear_cnt = clr;
        exp_q.push_back(exp_o);
        if (clr) begin
            cnt_model = 0;
            sat_model = 0;
        end else if (exp_o) begin
            if (cnt_model < 65535) cnt_model++;
            if (sat_model < 3) sat_model++;
        end
        @(negedge clk);
        e = exp_q.pop_front();
        check_val({tag, ".out"}, 32'(out), 32'(e));
        check_val({tag, ".out_sat"}, 32'(out_s), 32'(e));
        @(posedge clk);
        #1;
        clear_cnt = 1'b0;
        in_valid  = 1'b0;
        check_counts(tag);
    endtask

    task automatic configure(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                             input logic ov, input logic exp_err, input string tag);
        cfg_load = 1'b1;
        pattern  = p;
        pat_len  = l;
        overlap  = ov;
        in       = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check_val({tag, ".cfg_out"}, 32'(out), 32'(0));
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        check_val({tag, ".cfg_err"}, 32'(cfg_err), 32'(exp_err));
        check_counts(tag);
    endtask

    task automatic run_stream(input logic [15:0] bits, input logic [15:0] exp_o,
                              input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(bits[i], 1'b1, 1'b0, exp_o[i], $sformatf("%s[%0d]", tag, i));
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in        = 1'b0;
        in_valid  = 1'b0;
        cfg_load  = 1'b0;
        pattern   = '0;
        pat_len   = '0;
        overlap   = 1'b0;
        clear_cnt = 1'b0;
        #12;
        check_val("rst.out", 32'(out), 32'(0));
        check_val("rst.cfg_err", 32'(cfg_err), 32'(1));
        check_counts("rst");
        in = 1'b1; in_valid = 1'b1;
        #1;
        check_val("rst.out_valid", 32'(out), 32'(0));
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Unconfigured detector must stay silent.
        run_stream(16'b1111, 16'b0000, 4, "unconf");

        // 101 overlapping: stream 1,0,1,0,1 (index 0 first)
        configure(8'b0000_0101, 4'd3, 1'b1, 1'b0, "cfg101o");
        run_stream(16'b10101, 16'b10100, 5, "ov101");

        // 101 non-overlapping, upper pattern bits are garbage
        configure(8'b1110_0101, 4'd3, 1'b0, 1'b0, "cfg101n");
        run_stream(16'b10101, 16'b00100, 5, "nov101");

        // 1101 with 3-cycle idle gaps; in toggles during gaps
        configure(8'b0000_1101, 4'd4, 1'b1, 1'b0, "cfg1101");
        begin
            logic [3:0] seq;
            seq = 4'b1011;
            for (int i = 0; i < 4; i++) begin
                step(seq[i], 1'b1, 1'b0, (i == 3), $sformatf("gap.bit%0d", i));
                for (int g = 0; g < 3; g++) begin
                    step(g[0], 1'b0, 1'b0, 1'b0, $sformatf("gap.idle%0d_%0d", i, g));
                end
            end
        end

        // Saturation on the 2-bit instance, clear wins over a match
        step(1'b0, 1'b0, 1'b1, 1'b0, "preclr");
        configure(8'b0000_0011, 4'd2, 1'b1, 1'b0, "cfg11");
        run_stream(16'b111111, 16'b111110, 6, "sat");
        check_val("sat.final", 32'(match_count_s), 32'(3));
        step(1'b1, 1'b1, 1'b1, 1'b1, "sat.clr");
        check_val("sat.cleared", 32'(match_count_s), 32'(0));

        // Illegal lengths then the maximum length
        configure(8'hFF, 4'd1, 1'b1, 1'b1, "len1");
        run_stream(16'hFFFF, 16'h0000, 10, "len1");
        configure(8'hFF, 4'(MAX_LEN + 1), 1'b1, 1'b1, "len9");
        run_stream(16'hFFFF, 16'h0000, 10, "len9");
        configure(8'hFF, 4'(MAX_LEN), 1'b1, 1'b0, "len8");
        run_stream(16'h03FF, 16'h0380, 10, "len8");

        // Async reset in the middle of a pattern
        configure(8'b0000_0101, 4'd3, 1'b1, 1'b0, "cfgrst");
        step(1'b1, 1'b1, 1'b0, 1'b0, "mid.b0");
        step(1'b0, 1'b1, 1'b0, 1'b0, "mid.b1");
        in = 1'b1; in_valid = 1'b1;
        #1;
        check_val("mid.pre_rst_out", 32'(out), 32'(1));
        reset_n = 1'b0;
        cnt_model = 0;
        sat_model = 0;
        #1;
        check_val("mid.rst_out", 32'(out), 32'(0));
        check_val("mid.rst_cfg_err", 32'(cfg_err), 32'(1));
        check_counts("mid.rst");
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        configure(8'b0000_0101, 4'd3, 1'b1, 1'b0, "recfg");
        run_stream(16'b101, 16'b100, 3, "post");

        check_val("scoreboard.empty", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mealy_pattern_detector.md
Name: mealy_pattern_detector

Overview:
- Parametrised successor to the fixed-pattern Mealy serial detectors in this design.
- Detects a run-time programmable bit pattern of length 2..MAX_LEN on a serial input.
- Adds input-valid gating, an overlapping/non-overlapping mode select and a saturating match counter.
- Sits on the serial receive path. `out` is a combinational same-cycle strobe; `match_count` is a registered status value.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>= 2).
- CNT_W, 16, width of the match counter.
- LEN_W, $clog2(MAX_LEN+1), width of the pattern-length field (derived; do not override).

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- in, input, 1, serial data bit.
- in_valid, input, 1, `in` is sampled only when this is 1.
- cfg_load, input, 1, latch pattern/pat_len/overlap and flush history.
- pattern, input, MAX_LEN, pattern bits; pattern[pat_len-1] is the first bit received, pattern[0] the last.
- pat_len, input, LEN_W, pattern length.
- overlap, input, 1, 1 = overlapping detection, 0 = non-overlapping.
- clear_cnt, input, 1, synchronous clear of match_count.
- out, output, 1, Mealy match strobe.
- match_count, output, CNT_W, saturating count of matches.
- cfg_err, output, 1, latched pat_len is outside 2..MAX_LEN.

Behaviour:
- Registered state:
  - hist[MAX_LEN-2:0]: last received bits; hist[0] is the newest.
  - fill: number of valid history bits, 0..MAX_LEN-1.
  - Latched configuration: pattern, pat_len, overlap.
  - match_count and cfg_err.
- Reset (reset_n=0, asynchronous):
  - hist=0, fill=0, match_count=0, cfg_err=1.
  - Latched pat_len=0, so the detector is disabled; out=0.
  - Configuration is required after reset.
- cfg_load=1 (registered):
  - Latches the configuration inputs; hist=0, fill=0.
  - cfg_err = (pat_len<2 || pat_len>MAX_LEN).
  - `in` is ignored that cycle and out=0.
  - match_count is unchanged.
- match (combinational):
  - Condition: in_valid && !cfg_load && !cfg_err && fill >= pat_len-1.
  - And {hist[pat_len-2:0], in} equals pattern[pat_len-1:0].
  - Bits above pat_len are don't-care.
- out = match, with no register: zero latency, same cycle as the final pattern bit.
- History update, on in_valid=1 with cfg_load=0:
  - If match && overlap=0: hist=0, fill=0. The next match needs pat_len fresh bits.
  - Otherwise: hist shifts left with `in` inserted at hist[0], and fill=min(fill+1, MAX_LEN-1).
  - With overlap=1, history is kept, so a suffix of one match can start the next.
- in_valid=0: hist, fill and out hold/are 0; idle gaps do not break a partial match.
- match_count:
  - Increments on match.
  - Saturates at 2^CNT_W-1, with no wrap.
  - clear_cnt sets it to 0; clear_cnt wins over a simultaneous match.
- cfg_err=1 forces out=0 and suppresses counting. The history still shifts, but it is discarded by the next cfg_load.
- Reset asserted mid-pattern: the partial match is lost and out drops immediately (asynchronously).

Test Plan:
- pattern=101, pat_len=3, overlap=1; stream 1,0,1,0,1 (in_valid=1) -> out=1 on bits 3 and 5, coincident with `in`; match_count=2.
- Same stream, overlap=0 -> out=1 on bit 3 only; match_count=1.
- pattern=1101, pat_len=4; bits 1,1,0,1 with in_valid=0 gaps of 3 cycles between bits -> single out pulse on the 4th valid bit; out=0 in every gap cycle.
- CNT_W=2, pattern=11, overlap=1; 6 ones -> match_count 1,2,3,3,3; then clear_cnt=1 together with a 7th one -> match_count=0, out=1.
- pat_len=1 and pat_len=MAX_LEN+1 on cfg_load -> cfg_err=1, no out for any stream. Then pat_len=MAX_LEN, all-ones pattern -> first out on the 8th one.
- After the first two bits of 101, pulse reset_n=0 -> hist/fill/count=0, cfg_err=1. After reconfiguration, bit 1 alone gives no match; the full sequence 1,0,1 is needed.
